// File: rtl/mmio_periph_pkg.sv
// rtl/mmio_periph_pkg.sv - register map constants and store lane-merge helper
package mmio_periph_pkg;

  localparam logic [5:0] OFF_DUTY   = 6'h00;
  localparam logic [5:0] OFF_CTRL   = 6'h20;
  localparam logic [5:0] OFF_PERIOD = 6'h24;
  localparam logic [5:0] OFF_MILLIS = 6'h28;
  localparam logic [5:0] OFF_MICROS = 6'h2C;
  localparam logic [5:0] OFF_CMP    = 6'h30;
  localparam logic [5:0] OFF_STATUS = 6'h34;

  localparam int CTRL_PWM_EN    = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int STATUS_CMP_HIT = 0;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} store_size_e;

  function automatic store_size_e store_size(input logic [2:0] funct3);
    return funct3[1] ? SZ_WORD : (funct3[0] ? SZ_HALF : SZ_BYTE);
  endfunction

  // Places right-aligned store data into the addressed lanes of the old word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  funct3,
                                             input logic [1:0]  addr);
    logic [31:0] merged;
    merged = old;
    case (store_size(funct3))
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (addr[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged[{addr, 3'b000} +: 8] = wdata[7:0];
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/mmio_periph_if.sv
// rtl/mmio_periph_if.sv - store/load port shared with data memory
interface mmio_periph_if;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        read_hit;

  modport master (
    output write_mem, funct3, write_address, write_data, read_address,
    input  read_data, read_hit
  );

  modport slave (
    input  write_mem, funct3, write_address, write_data, read_address,
    output read_data, read_hit
  );
endinterface

// File: rtl/mmio_periph_tick_divider.sv
// rtl/mmio_periph_tick_divider.sv - prescaled 32-bit free-running counter with tick pulse
module tick_divider #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        tick_o,
  output logic [31:0] count_o
);
  localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [31:0]   count_q, count_d;

  // tick is high in the cycle before the count advances
  assign tick_o  = (pre_q == PRE_LAST);
  assign count_o = count_q;

  always_comb begin
    pre_d   = tick_o ? '0 : pre_q + PW'(1);
    count_d = tick_o ? count_q + 32'd1 : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      count_q <= '0;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - PWM channels, ms/us timers and ms compare IRQ in a 64-byte MMIO window
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned NUM_PWM   = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFFC0
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_periph_if.slave       bus,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);
  logic [PWM_BITS-1:0] duty_q   [NUM_PWM];
  logic [PWM_BITS-1:0] duty_d   [NUM_PWM];
  logic [PWM_BITS-1:0] shadow_q [NUM_PWM];
  logic [PWM_BITS-1:0] shadow_d [NUM_PWM];
  logic [1:0]          ctrl_q, ctrl_d;
  logic [PWM_BITS-1:0] period_q, period_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]         cmp_q, cmp_d;
  logic                cmp_hit_q, cmp_hit_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rhit_q, rhit_d;

  logic [31:0] millis, micros;
  logic        ms_tick, us_tick_unused;

  tick_divider #(.DIV(CLK_HZ / 1000)) u_millis (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_o  (ms_tick),
    .count_o (millis)
  );

  tick_divider #(.DIV(CLK_HZ / 1000000)) u_micros (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_o  (us_tick_unused),
    .count_o (micros)
  );

  logic        wr_hit, rd_hit;
  logic [3:0]  wr_idx, rd_idx;
  logic [5:0]  wr_off;
  logic [1:0]  rd_lane_unused;
  logic [31:0] reg_words [16];
  logic [31:0] wr_new, wr_ones;

  assign wr_hit         = bus.write_mem && (bus.write_address[31:6] == BASE_ADDR[31:6]);
  assign rd_hit         = (bus.read_address[31:6] == BASE_ADDR[31:6]);
  assign wr_idx         = bus.write_address[5:2];
  assign wr_off         = {wr_idx, 2'b00};
  assign rd_idx         = bus.read_address[5:2];
  assign rd_lane_unused = bus.read_address[1:0];

  // Word view of every register; unimplemented words and bits read as 0
  always_comb begin
    for (int k = 0; k < 16; k++) reg_words[k] = '0;
    for (int i = 0; i < NUM_PWM; i++) reg_words[OFF_DUTY[5:2] + 4'(i)] = 32'(duty_q[i]);
    reg_words[OFF_CTRL[5:2]]                 = {30'd0, ctrl_q};
    reg_words[OFF_PERIOD[5:2]]               = 32'(period_q);
    reg_words[OFF_MILLIS[5:2]]               = millis;
    reg_words[OFF_MICROS[5:2]]               = micros;
    reg_words[OFF_CMP[5:2]]                  = cmp_q;
    reg_words[OFF_STATUS[5:2]][STATUS_CMP_HIT] = cmp_hit_q;
  end

  // STATUS clears only on written 1s, so its mask is merged against zero, not the old word
  assign wr_new  = lane_merge(reg_words[wr_idx], bus.write_data, bus.funct3, bus.write_address[1:0]);
  assign wr_ones = lane_merge(32'd0, bus.write_data, bus.funct3, bus.write_address[1:0]);

  always_comb begin
    duty_d    = duty_q;
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    cmp_d     = cmp_q;
    cmp_hit_d = cmp_hit_q;
    if (wr_hit) begin
      for (int i = 0; i < NUM_PWM; i++)
        if (wr_off == OFF_DUTY + 6'(4 * i)) duty_d[i] = wr_new[PWM_BITS-1:0];
      if (wr_off == OFF_CTRL)   ctrl_d   = wr_new[1:0];
      if (wr_off == OFF_PERIOD) period_d = wr_new[PWM_BITS-1:0];
      if (wr_off == OFF_CMP)    cmp_d    = wr_new;
      if (wr_off == OFF_STATUS && wr_ones[STATUS_CMP_HIT]) cmp_hit_d = 1'b0;
    end
    if (ms_tick && (millis + 32'd1 == cmp_q)) cmp_hit_d = 1'b1;
  end

  // cnt may sit above a freshly lowered PERIOD; >= brings it back to 0 next cycle
  always_comb begin
    cnt_d    = (cnt_q >= period_q) ? '0 : cnt_q + PWM_BITS'(1);
    shadow_d = shadow_q;
    if (!ctrl_q[CTRL_PWM_EN] || (cnt_q == period_q)) shadow_d = duty_q;
  end

  always_comb begin
    for (int i = 0; i < NUM_PWM; i++)
      pwm_out[i] = ctrl_q[CTRL_PWM_EN] && (cnt_q < shadow_q[i]);
  end

  always_comb begin
    rdata_d = rd_hit ? reg_words[rd_idx] : 32'd0;
    rhit_d  = rd_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PWM; i++) begin
        duty_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      ctrl_q    <= '0;
      period_q  <= '1;
      cnt_q     <= '0;
      cmp_q     <= 32'hFFFFFFFF;
      cmp_hit_q <= 1'b0;
      rdata_q   <= '0;
      rhit_q    <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      shadow_q  <= shadow_d;
      ctrl_q    <= ctrl_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      cmp_q     <= cmp_d;
      cmp_hit_q <= cmp_hit_d;
      rdata_q   <= rdata_d;
      rhit_q    <= rhit_d;
    end
  end

  assign irq           = cmp_hit_q & ctrl_q[CTRL_IRQ_EN];
  assign bus.read_data = rdata_q;
  assign bus.read_hit  = rhit_q;
endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - randomized register, PWM and timer checks against a behavioural model
module tb_mmio_periph;
  localparam int unsigned CLK_HZ   = 12000000;
  localparam int          NUM_PWM  = 4;
  localparam int          PWM_BITS = 8;
  localparam logic [31:0] BASE     = 32'hFFFFFFC0;
  localparam int          MS_DIV   = CLK_HZ / 1000;
  localparam int          US_DIV   = CLK_HZ / 1000000;
  localparam logic [31:0] PMASK    = (32'd1 << PWM_BITS) - 32'd1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_PWM-1:0] pwm_out;
  logic               irq;

  mmio_periph_if bus();

  mmio_periph #(
    .CLK_HZ   (CLK_HZ),
    .NUM_PWM  (NUM_PWM),
    .PWM_BITS (PWM_BITS),
    .BASE_ADDR(BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [31:0] m_duty [NUM_PWM];
  logic [31:0] m_ctrl, m_period, m_cmp;

  function automatic logic [31:0] model_word(input int off);
    if (off < 4 * NUM_PWM) return m_duty[off / 4];
    case (off)
      'h20:    return m_ctrl;
      'h24:    return m_period;
      'h30:    return m_cmp;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    int sz, start, off;
    logic [31:0] w;
    if ((addr >> 6) != (BASE >> 6)) return;
    sz    = f3[1] ? 4 : (f3[0] ? 2 : 1);
    off   = int'(addr[5:2]) * 4;
    start = int'(addr[1:0]) & ~(sz - 1);
    w     = model_word(off);
    for (int b = 0; b < sz; b++) w[8*(start+b) +: 8] = data[8*b +: 8];
    if (off < 4 * NUM_PWM) m_duty[off / 4] = w & PMASK;
    else if (off == 'h20)  m_ctrl = w & 32'h3;
    else if (off == 'h24)  m_period = w & PMASK;
    else if (off == 'h30)  m_cmp = w;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    bus.write_mem     = 1'b1;
    bus.write_address = addr;
    bus.write_data    = data;
    bus.funct3        = f3;
    @(negedge clk);
    bus.write_mem     = 1'b0;
  endtask

  task automatic write_model(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    bus_write(addr, data, f3);
    model_store(addr, data, f3);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
    bus.read_address = addr;
    @(negedge clk);
    data = bus.read_data;
    hit  = bus.read_hit;
  endtask

  task automatic wait_level(input int ch, input logic lvl, output bit ok);
    int n = 0;
    while (pwm_out[ch] !== lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = (pwm_out[ch] === lvl);
  endtask

  task automatic run_len(input int ch, input logic lvl, output int n);
    n = 0;
    while (pwm_out[ch] === lvl && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic measure(input int ch, output int hi, output int lo);
    bit ok0, ok1;
    hi = 0;
    lo = 0;
    wait_level(ch, 1'b0, ok0);
    wait_level(ch, 1'b1, ok1);
    if (ok0 && ok1) begin
      run_len(ch, 1'b1, hi);
      run_len(ch, 1'b0, lo);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        h;
    int          hi, lo, n;
    bit          ok;

    bus.write_mem = 1'b0; bus.funct3 = 3'd0; bus.write_address = '0;
    bus.write_data = '0;  bus.read_address = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_read_data", bus.read_data, 32'd0);
    check_eq("reset_read_hit", 32'(bus.read_hit), 32'd0);
    check_eq("reset_pwm", 32'(pwm_out), 32'd0);
    check_eq("reset_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_PWM; i++) m_duty[i] = 32'd0;
    m_ctrl = 32'd0; m_period = PMASK; m_cmp = 32'hFFFFFFFF;

    bus_read(BASE + 32'h24, d, h);
    check_eq("period_reset", d, 32'hFF);
    check_eq("window_hit", 32'(h), 32'd1);
    bus_read(BASE + 32'h30, d, h);
    check_eq("cmp_reset", d, 32'hFFFFFFFF);
    bus_read(BASE - 32'd4, d, h);
    check_eq("unmapped_data", d, 32'd0);
    check_eq("unmapped_hit", 32'(h), 32'd0);
    bus_read(BASE + 32'h3C, d, h);
    check_eq("unimpl_data", d, 32'd0);
    check_eq("unimpl_hit", 32'(h), 32'd1);

    bus.read_address = BASE + 32'h30;
    write_model(BASE + 32'h30, 32'd0, 3'b010);
    check_eq("rw_same_cycle_old", bus.read_data, 32'hFFFFFFFF);
    bus_read(BASE + 32'h30, d, h);
    check_eq("cmp_after_write", d, 32'd0);

    write_model(BASE + 32'h32, 32'hAB, 3'b000);
    bus_read(BASE + 32'h30, d, h);
    check_eq("cmp_byte_store", d, 32'h00AB0000);
    write_model(BASE + 32'h30, 32'h1234, 3'b001);
    bus_read(BASE + 32'h30, d, h);
    check_eq("cmp_half_store", d, 32'h00AB1234);
    write_model(BASE + 32'h28, 32'h55555555, 3'b010);
    bus_read(BASE + 32'h28, d, h);
    check_eq("millis_ro", d, 32'((cyc - 1) / MS_DIV));

    for (int it = 0; it < 150; it++) begin
      logic [31:0] a, wd;
      logic [2:0]  f3;
      int          off;
      off = 4 * int'($urandom_range(0, 15));
      if (off == 'h34) off = 'h30;
      f3 = 3'($urandom_range(0, 2));
      a  = BASE + 32'(off) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a - 32'h40;
      wd = $urandom;
      write_model(a, wd, f3);
      off = 4 * int'($urandom_range(0, 15));
      if (off == 'h28 || off == 'h2C || off == 'h34) off = 'h24;
      bus_read(BASE + 32'(off), d, h);
      check_eq($sformatf("rand_reg_%02h", off), d, model_word(off));
    end

    write_model(BASE + 32'h20, 32'd0, 3'b010);
    write_model(BASE + 32'h24, 32'hFF, 3'b010);
    for (int i = 0; i < NUM_PWM; i++) write_model(BASE + 32'(4 * i), 32'd0, 3'b010);
    write_model(BASE, 32'h40, 3'b010);
    write_model(BASE + 32'h20, 32'd1, 3'b010);
    measure(0, hi, lo);
    check_eq("pwm64_high", 32'(hi), 32'd64);
    check_eq("pwm64_low", 32'(lo), 32'd192);

    wait_level(0, 1'b0, ok);
    wait_level(0, 1'b1, ok);
    check_eq("mid_rise_seen", 32'(ok), 32'd1);
    write_model(BASE, 32'hC0, 3'b010);
    run_len(0, 1'b1, n);
    check_eq("mid_write_cur_high", 32'(n + 1), 32'd64);
    run_len(0, 1'b0, n);
    check_eq("mid_write_cur_low", 32'(n), 32'd192);
    run_len(0, 1'b1, n);
    check_eq("mid_write_next_high", 32'(n), 32'd192);

    for (int r = 0; r < 3; r++) begin
      int ch, p, dd;
      ch = int'($urandom_range(0, NUM_PWM - 1));
      p  = int'($urandom_range(4, 60));
      dd = int'($urandom_range(1, p));
      write_model(BASE + 32'h24, 32'(p), 3'b010);
      write_model(BASE + 32'(4 * ch), 32'(dd), 3'b010);
      repeat (2 * (p + 1)) @(negedge clk);
      measure(ch, hi, lo);
      check_eq($sformatf("rand_pwm%0d_p%0d_high", ch, p), 32'(hi), 32'(dd));
      check_eq($sformatf("rand_pwm%0d_p%0d_low", ch, p), 32'(lo), 32'(p + 1 - dd));
    end

    write_model(BASE + 32'h24, 32'd9, 3'b010);
    write_model(BASE + 32'h04, 32'd10, 3'b010);
    repeat (25) @(negedge clk);
    n = 0;
    for (int c = 0; c < 30; c++) begin n += int'(pwm_out[1]); @(negedge clk); end
    check_eq("duty_gt_period_high", 32'(n), 32'd30);
    write_model(BASE + 32'h04, 32'd0, 3'b010);
    repeat (11) @(negedge clk);
    n = 0;
    for (int c = 0; c < 30; c++) begin n += int'(pwm_out[1]); @(negedge clk); end
    check_eq("duty0_low", 32'(n), 32'd0);
    write_model(BASE + 32'h24, 32'd0, 3'b010);
    write_model(BASE + 32'h04, 32'd1, 3'b010);
    repeat (5) @(negedge clk);
    n = 0;
    for (int c = 0; c < 20; c++) begin n += int'(pwm_out[1]); @(negedge clk); end
    check_eq("period0_high", 32'(n), 32'd20);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      bus_read(BASE + 32'h2C, d, h);
      check_eq("micros", d, 32'((cyc - 1) / US_DIV));
    end
    bus_read(BASE + 32'h28, d, h);
    check_eq("millis", d, 32'((cyc - 1) / MS_DIV));

    write_model(BASE + 32'h34, 32'd1, 3'b010);
    write_model(BASE + 32'h20, 32'd3, 3'b010);
    write_model(BASE + 32'h30, 32'd3, 3'b010);
    check_eq("irq_idle", 32'(irq), 32'd0);
    while (irq !== 1'b1 && cyc < 40000) @(negedge clk);
    check_eq("irq_rise_cycle", 32'(cyc), 32'd36000);
    bus_read(BASE + 32'h34, d, h);
    check_eq("status_hit", d, 32'd1);
    bus_write(BASE + 32'h34, 32'd1, 3'b000);
    check_eq("irq_after_w1c", 32'(irq), 32'd0);

    write_model(BASE + 32'h30, 32'd4, 3'b010);
    while (cyc < 47999) @(negedge clk);
    check_eq("irq_before_set2", 32'(irq), 32'd0);
    bus_write(BASE + 32'h34, 32'd1, 3'b010);
    check_eq("set_beats_w1c_irq", 32'(irq), 32'd1);
    check_eq("set_beats_w1c_cycle", 32'(cyc), 32'd48000);

    write_model(BASE + 32'h24, 32'hFF, 3'b010);
    write_model(BASE, 32'h80, 3'b010);
    wait_level(0, 1'b0, ok);
    wait_level(0, 1'b1, ok);
    check_eq("pwm_high_before_reset", 32'(pwm_out[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_pwm", 32'(pwm_out), 32'd0);
    check_eq("async_reset_irq", 32'(irq), 32'd0);
    check_eq("async_reset_read_hit", 32'(bus.read_hit), 32'd0);
    check_eq("async_reset_read_data", bus.read_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(BASE + 32'h28, d, h);
    check_eq("millis_restart", d, 32'd0);
    repeat (100) @(negedge clk);
    bus_read(BASE + 32'h2C, d, h);
    check_eq("micros_restart", d, 32'((cyc - 1) / US_DIV));
    bus_read(BASE + 32'h24, d, h);
    check_eq("period_after_reset", d, 32'hFF);
    bus_read(BASE + 32'h20, d, h);
    check_eq("ctrl_after_reset", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
